// File: rtl/tcb_pkg.sv
// Shared TCB library types: SRAM subordinate state encoding and sizing helper.
package tcb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } tcb_sram_state_t;

  // Width of an index into n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcb_lib_rsp_delay.sv
// Fixed-latency response delay line with async flush; payload is zero whenever valid is low.
module tcb_lib_rsp_delay #(
  parameter int unsigned DLY = 1,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         src_vld,
  input  logic [W-1:0] src_dat,
  output logic         dst_vld,
  output logic [W-1:0] dst_dat
);

  generate
    if (DLY == 0) begin : g_pass
      assign dst_vld = src_vld;
      assign dst_dat = src_vld ? src_dat : '0;
    end else begin : g_pipe
      logic [DLY-1:0] vld_p;
      logic [W-1:0]   dat_p [DLY];

      // Only the valid bits are flushed; stale data is masked at the output.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= src_vld;
          for (int i = 1; i < DLY; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        dat_p[0] <= src_dat;
        for (int i = 1; i < DLY; i++) dat_p[i] <= dat_p[i-1];
      end

      assign dst_vld = vld_p[DLY-1];
      assign dst_dat = dst_vld ? dat_p[DLY-1] : '0;
    end
  endgenerate

endmodule

// File: rtl/tcb_lib_sub_sram.sv
// TCB subordinate backed by a flop array: self-clears after reset, then serves one transfer per cycle.
module tcb_lib_sub_sram
  import tcb_pkg::*;
#(
  parameter int unsigned DLY = 1,
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned SIZ = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tcb_vld,
  output logic               tcb_rdy,
  input  logic               tcb_wen,
  input  logic [ADR-1:0]     tcb_adr,
  input  logic [DAT/8-1:0]   tcb_ben,
  input  logic [DAT-1:0]     tcb_wdt,
  output logic               tcb_rsp,
  output logic [DAT-1:0]     tcb_rdt,
  output logic               tcb_err
);

  localparam int unsigned BEN = DAT / 8;
  localparam int unsigned ABW = $clog2(BEN);
  localparam int unsigned IDW = ADR - ABW;
  localparam int unsigned MAW = idx_width(SIZ);

  typedef struct packed {
    logic           rsp;
    logic           err;
    logic [DAT-1:0] rdt;
  } tcb_sram_rsp_t;

  tcb_sram_state_t state_q, state_d;
  logic [MAW-1:0]  cnt_q, cnt_d;

  logic [DAT-1:0]  mem [SIZ];

  logic [IDW-1:0]  idx;
  logic [MAW-1:0]  mem_adr;
  logic            xfr;
  logic            dec_err;
  logic            wr_en;
  logic [DAT-1:0]  rd_dat;
  logic [DAT-1:0]  wr_dat;

  tcb_sram_rsp_t   rsp_p0;
  tcb_sram_rsp_t   rsp_dly;
  logic            rsp_vld;

  generate
    if (ABW > 0) begin : g_lsb
      logic unused_adr_lsb;
      assign unused_adr_lsb = ^tcb_adr[ABW-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (cnt_q == MAW'(SIZ - 1)) state_d = RUN;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign tcb_rdy = (state_q == RUN);

  // Transfer decode: out-of-range word or empty byte mask is an error with no side effects.
  assign idx     = tcb_adr[ADR-1:ABW];
  assign mem_adr = idx[MAW-1:0];
  assign xfr     = tcb_vld & tcb_rdy;
  assign dec_err = ({1'b0, idx} >= (IDW+1)'(SIZ)) || (tcb_ben == '0);
  assign wr_en   = xfr & tcb_wen & ~dec_err;
  assign rd_dat  = mem[mem_adr];

  always_comb begin
    wr_dat = rd_dat;
    for (int i = 0; i < BEN; i++) begin
      if (tcb_ben[i]) wr_dat[8*i +: 8] = tcb_wdt[8*i +: 8];
    end
  end

  // Array has no reset; INIT walks every word back to zero instead.
  always_ff @(posedge clk) begin
    if (state_q == INIT) mem[cnt_q]   <= '0;
    else if (wr_en)      mem[mem_adr] <= wr_dat;
  end

  // ---- stage p0: response formed in the transfer cycle ----
  always_comb begin
    rsp_p0     = '0;
    rsp_p0.rsp = xfr;
    rsp_p0.err = xfr & dec_err;
    if (xfr && !dec_err && !tcb_wen) rsp_p0.rdt = rd_dat;
  end

  tcb_lib_rsp_delay #(
    .DLY (DLY),
    .W   ($bits(tcb_sram_rsp_t))
  ) u_rsp_delay (
    .clk     (clk),
    .rst     (rst),
    .src_vld (rsp_p0.rsp),
    .src_dat (rsp_p0),
    .dst_vld (rsp_vld),
    .dst_dat (rsp_dly)
  );

  assign tcb_rsp = rsp_vld;
  assign tcb_err = rsp_dly.err;
  assign tcb_rdt = rsp_dly.rdt;

endmodule

// File: tb/tb_tcb_lib_sub_sram.sv
// Bench for tcb_lib_sub_sram: three builds (DLY 0/1/4) share one request stream and a memory model.
module tb_tcb_lib_sub_sram;

  localparam int SIZ = 64;
  localparam int DL [3] = '{0, 1, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vld = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] adr = '0;
  logic [3:0]  ben = '0;
  logic [31:0] wdt = '0;

  logic [2:0]       rdy, rsp, err;
  logic [2:0][31:0] rdt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tcb_lib_sub_sram #(.DLY(0), .ADR(32), .DAT(32), .SIZ(SIZ)) d0 (
    .clk(clk), .rst(rst), .tcb_vld(vld), .tcb_rdy(rdy[0]), .tcb_wen(wen), .tcb_adr(adr),
    .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rsp(rsp[0]), .tcb_rdt(rdt[0]), .tcb_err(err[0]));
  tcb_lib_sub_sram #(.DLY(1), .ADR(32), .DAT(32), .SIZ(SIZ)) d1 (
    .clk(clk), .rst(rst), .tcb_vld(vld), .tcb_rdy(rdy[1]), .tcb_wen(wen), .tcb_adr(adr),
    .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rsp(rsp[1]), .tcb_rdt(rdt[1]), .tcb_err(err[1]));
  tcb_lib_sub_sram #(.DLY(4), .ADR(32), .DAT(32), .SIZ(SIZ)) d4 (
    .clk(clk), .rst(rst), .tcb_vld(vld), .tcb_rdy(rdy[2]), .tcb_wen(wen), .tcb_adr(adr),
    .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rsp(rsp[2]), .tcb_rdt(rdt[2]), .tcb_err(err[2]));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: word memory, ready after SIZ clocked cycles out of reset,
  // and a per-cycle history of the response each transfer should produce.
  logic [31:0] mm [SIZ];
  int          ic = 0;
  int          cyc = 0;
  int          last_rst = 0;
  bit          hv [16];
  bit          he [16];
  logic [31:0] hd [16];

  always @(posedge clk) ic = rst ? ((ic < SIZ) ? ic + 1 : ic) : 0;

  always @(negedge clk) begin
    bit          rdy_e, ev, ee;
    logic [31:0] ed;
    int          widx, t;
    if (!rst) begin
      last_rst = cyc;
      for (int i = 0; i < SIZ; i++) mm[i] = '0;
    end
    rdy_e = rst && (ic >= SIZ);
    ev = 1'b0; ee = 1'b0; ed = '0;
    if (rdy_e && vld) begin
      ev   = 1'b1;
      widx = int'(adr >> 2);
      if (widx >= SIZ || ben == 4'd0) begin
        ee = 1'b1;
      end else if (!wen) begin
        ed = mm[widx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (ben[b]) mm[widx][8*b +: 8] = wdt[8*b +: 8];
      end
    end
    hv[cyc % 16] = ev; he[cyc % 16] = ee; hd[cyc % 16] = ed;
    for (int k = 0; k < 3; k++) begin
      t = cyc - DL[k];
      if (t >= 0 && t > last_rst) begin
        ev = hv[t % 16]; ee = he[t % 16]; ed = hd[t % 16];
      end else begin
        ev = 1'b0; ee = 1'b0; ed = '0;
      end
      check($sformatf("rdy_d%0d", DL[k]), 64'(rdy[k]), 64'(rdy_e));
      check($sformatf("rsp_d%0d", DL[k]), 64'(rsp[k]), 64'(ev));
      check($sformatf("err_d%0d", DL[k]), 64'(err[k]), 64'(ee));
      check($sformatf("rdt_d%0d", DL[k]), 64'(rdt[k]), 64'(ed));
    end
    cyc++;
  end

  task automatic req(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    @(posedge clk); #1;
    vld = 1'b1; wen = w; adr = a; ben = b; wdt = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vld = 1'b0; wen = 1'b0; adr = '0; ben = '0; wdt = '0;
    end
  endtask

  // Present a request and hold it until the subordinate accepts it.
  task automatic req_hold(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    int n;
    req(w, a, b, d);
    n = 0;
    while (!rdy[1] && n < SIZ + 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy[1]) check("rdy_timeout", 64'(rdy[1]), 64'd1);
  endtask

  initial begin
    idle(3);
    @(posedge clk); #1;
    rst = 1'b1;
    req_hold(1'b0, 32'h00, 4'hF, '0);

    req(1'b1, 32'h30, 4'hF, 32'h7654_3210);
    req(1'b1, 32'h30, 4'h2, 32'h0000_AB00);
    req(1'b0, 32'h30, 4'hF, '0);
    idle(2);

    req(1'b1, 32'h10, 4'h1, 32'h0000_0010);
    req(1'b1, 32'h11, 4'h2, 32'h0000_3200);
    req(1'b1, 32'h12, 4'h4, 32'h0054_0000);
    req(1'b1, 32'h13, 4'h8, 32'h7600_0000);
    req(1'b0, 32'h10, 4'h1, '0);
    idle(6);

    req(1'b0, 32'h100, 4'hF, '0);
    req(1'b1, 32'h30, 4'h0, 32'hDEAD_BEEF);
    req(1'b0, 32'h30, 4'hF, '0);
    idle(6);

    // Reset with three reads still inside the DLY=4 pipeline.
    req(1'b0, 32'h10, 4'hF, '0);
    req(1'b0, 32'h30, 4'hF, '0);
    req(1'b0, 32'h10, 4'hF, '0);
    idle(1);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    req_hold(1'b0, 32'h30, 4'hF, '0);
    idle(6);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (i == 700) rst = 1'b0;
      if (i == 703) rst = 1'b1;
      vld = ($urandom_range(0, 3) != 0);
      wen = $urandom_range(0, 1);
      adr = $urandom_range(0, 32'h11F);
      ben = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      wdt = $urandom;
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tcb_lib_sub_sram.md
# tcb_lib_sub_sram

Synthesizable TCB subordinate: a flop-based memory that answers TCB manager transfers with a fixed response delay. It is the responder end of the TCB link and replaces the behavioural memory model wherever RTL simulation, lint or FPGA builds need a real subordinate behind converters and interconnect. After reset it runs a self-clearing sequence, then accepts one transfer per cycle. Every accepted transfer gets exactly one response, DLY cycles later.

## Interface
Parameters:
- DLY, 1: response delay in cycles, legal range 0..4.
- ADR, 32: byte address width.
- DAT, 32: data width, multiple of 8; BEN = DAT/8.
- SIZ, 64: memory depth in DAT-wide words; any value 1..2**(ADR-log2(BEN)).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous and active-low.
- tcb_vld  in  1  manager request valid.
- tcb_rdy  out  1  subordinate ready; a transfer occurs when tcb_vld & tcb_rdy.
- tcb_wen  in  1  1 = write, 0 = read.
- tcb_adr  in  ADR  byte address; word index = tcb_adr[ADR-1:log2(BEN)], low bits ignored.
- tcb_ben  in  BEN  byte enables.
- tcb_wdt  in  DAT  write data.
- tcb_rsp  out  1  response strobe, high in the response cycle.
- tcb_rdt  out  DAT  read data.
- tcb_err  out  1  error response.

## Operation
- State machine INIT, RUN:
  - Release of rst enters INIT with clear counter cnt = 0.
  - In INIT, word cnt is written to all zeros and cnt increments each cycle.
  - At cnt == SIZ-1 the FSM moves to RUN on the next edge.
- tcb_rdy is 0 in INIT and 1 in RUN. No other back-pressure exists.
- Transfer decode, per transfer:
  - The transfer is in error when word index >= SIZ or tcb_ben == 0.
  - On error: no memory update, response has tcb_rdt = 0 and tcb_err = 1.
- Write, no error:
  - Bytes with tcb_ben[i] = 1 take tcb_wdt[8i+7:8i]; other bytes are unchanged.
  - Response has tcb_err = 0 and tcb_rdt = 0.
- Read, no error:
  - The response returns the full word; tcb_ben does not mask read data.
  - Data is sampled from the array in the transfer cycle, before any write in that same cycle takes effect.
- Response path: a DLY-deep delay line carries {rsp, rdt, err}.
  - DLY = 0: the response is combinational in the transfer cycle.
  - Outputs are 0 whenever tcb_rsp = 0.
- Reset asserted mid-operation:
  - The delay line is flushed and in-flight responses are dropped.
  - Memory contents are not reset asynchronously; they are cleared again by INIT.
- Reset values: tcb_rdy = 0, tcb_rsp = 0, tcb_rdt = 0, tcb_err = 0, FSM = INIT, cnt = 0.

## Timing
- INIT lasts exactly SIZ cycles after rst deassertion; tcb_rdy rises on edge SIZ.
- A transfer at cycle n produces its response at cycle n+DLY.
- Back-to-back transfers are accepted every cycle, so responses are back-to-back.
- A write at cycle n followed by a read of the same word at cycle n+1 returns the new data.
- A write and a read of the same word cannot occur in the same cycle (single port).
- tcb_vld asserted during INIT is not a transfer and produces no response. The request must be held until tcb_rdy; the bench checks this.

## Structure
- tcb_pkg gains:
  - tcb_sram_state_t, an enum {INIT, RUN}.
  - A packed tcb_sram_rsp_t struct {rsp, err, rdt} parameterized through DAT in the module.
- Sub-module tcb_lib_rsp_delay:
  - Parameterized depth DLY, generic payload, async active-low flush.
  - Reusable by other subordinates.
- The top module holds the FSM, clear counter, decode and memory array.

## Test plan
- Reset, SIZ=64, DLY=1 -> tcb_rdy=0 for 64 cycles, then 1. A read at 0x00 returns rdt=0x00000000, err=0.
- Write 0x76543210 to 0x30 with ben=0xF, then ben=0x2 with wdt=0x0000AB00 -> read 0x30 returns 0x7654AB10 one cycle after the read transfer.
- Four byte writes to 0x10..0x13 (0x10, 0x32, 0x54, 0x76 on their lanes), then a read of 0x10 -> 0x76543210. Back-to-back transfers give tcb_rsp high for 5 consecutive cycles.
- Read at word index 64 (adr 0x100), and a write with ben=0 -> err=1, rdt=0, memory unchanged.
- DLY=0 and DLY=4 builds -> read response appears in the transfer cycle and 4 cycles later respectively, with data 0x76543210.
- rst low while 3 responses are in flight with DLY=4 -> no tcb_rsp after reset. INIT reruns and a prior write at 0x30 reads back 0.
